// File: rtl/core_bus_arbiter_pkg.sv
// core_bus_arbiter_pkg: shared types for the core-side bus arbiter.
// Defines the ibus/dbus/cbus request and response payloads and the arbiter FSM and select enums.
// It also provides the ibus->cbus and dbus->cbus request converters.
package core_bus_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned IDAT_W = 32;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2} arb_state_t;
    typedef enum logic {SEL_I = 1'b0, SEL_D = 1'b1} arb_sel_t;

    typedef enum logic [2:0] {MSIZE1 = 3'd0, MSIZE2 = 3'd1, MSIZE4 = 3'd2, MSIZE8 = 3'd3} msize_t;
    typedef enum logic [3:0] {MLEN1 = 4'd0, MLEN2 = 4'd1, MLEN4 = 4'd3, MLEN8 = 4'd7, MLEN16 = 4'd15} mlen_t;
    typedef enum logic [1:0] {AXI_BURST_FIXED = 2'b00, AXI_BURST_INCR = 2'b01, AXI_BURST_WRAP = 2'b10} axi_burst_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic              addr_ok;
        logic              data_ok;
        logic [IDAT_W-1:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        msize_t            size;
        logic [STRB_W-1:0] strobe;
        logic [DATA_W-1:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic              addr_ok;
        logic              data_ok;
        logic [DATA_W-1:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic              valid;
        logic              is_write;
        msize_t            size;
        logic [ADDR_W-1:0] addr;
        logic [STRB_W-1:0] strobe;
        logic [DATA_W-1:0] data;
        mlen_t             len;
        axi_burst_t        burst;
    } cbus_req_t;

    typedef struct packed {
        logic              ready;
        logic              last;
        logic [DATA_W-1:0] data;
    } cbus_resp_t;

    // Instruction fetch: always a single 4-byte read.
    function automatic cbus_req_t ibus_to_cbus(ibus_req_t r);
        cbus_req_t c;
        c          = '0;
        c.valid    = r.valid;
        c.is_write = 1'b0;
        c.size     = MSIZE4;
        c.addr     = r.addr;
        c.strobe   = '0;
        c.len      = MLEN1;
        c.burst    = AXI_BURST_FIXED;
        return c;
    endfunction

    // Data access: any strobe bit set makes it a write.
    function automatic cbus_req_t dbus_to_cbus(dbus_req_t r);
        cbus_req_t c;
        c          = '0;
        c.valid    = r.valid;
        c.is_write = |r.strobe;
        c.size     = r.size;
        c.addr     = r.addr;
        c.strobe   = r.strobe;
        c.data     = r.data;
        c.len      = MLEN1;
        c.burst    = AXI_BURST_FIXED;
        return c;
    endfunction

endpackage

// File: rtl/core_bus_arbiter_if.sv
// core_bus_arbiter_if: bundles the core-side ibus/dbus and the memory-side cbus.
// slave modport: arbiter view (ireq/dreq/cresp in, iresp/dresp/creq out).
// master modport: the surrounding core + memory view (the reverse).
interface core_bus_arbiter_if;
    import core_bus_arbiter_pkg::*;

    ibus_req_t  ireq;
    ibus_resp_t iresp;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    cbus_req_t  creq;
    cbus_resp_t cresp;

    modport slave  (input ireq, dreq, cresp, output iresp, dresp, creq);
    modport master (output ireq, dreq, cresp, input iresp, dresp, creq);
endinterface

// File: rtl/bus_arb_grant.sv
// bus_arb_grant: picks the ibus/dbus winner while the arbiter is idle and keeps the fairness state.
// Ports: clk, reset_n (async active-low), arb_en (arbiter idle), ivalid/dvalid (request valids),
//        grant_c (a grant happens this cycle), sel_c (winner).
// CORE_BUS_ARB_RR_EN defined: round-robin on the last winner.
// Undefined: dbus has priority, limited to MAX_STARVE grants in a row while ibus waits (MAX_STARVE >= 1).
module bus_arb_grant
    import core_bus_arbiter_pkg::*;
#(
    parameter int unsigned MAX_STARVE = 4
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     arb_en,
    input  logic     ivalid,
    input  logic     dvalid,
    output logic     grant_c,
    output arb_sel_t sel_c
);

`ifdef CORE_BUS_ARB_RR_EN
    arb_sel_t rr_last;

    // Winner select: alternate when both request, otherwise take whoever is valid.
    always_comb begin
        grant_c = arb_en & (ivalid | dvalid);
        sel_c   = SEL_I;
        if (ivalid && dvalid) begin
            sel_c = (rr_last == SEL_I) ? SEL_D : SEL_I;
        end else if (dvalid) begin
            sel_c = SEL_D;
        end
    end

    // Last-winner register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_last <= SEL_I;
        end else if (grant_c) begin
            rr_last <= sel_c;
        end
    end
`else
    localparam int unsigned CNT_W = $clog2(MAX_STARVE + 1);

    logic [CNT_W-1:0] starve_cnt;
    logic             d_win;

    // Winner select: the starvation limit only bites when ibus is actually waiting,
    // otherwise a lone dbus request at the limit could never be served.
    always_comb begin
        d_win   = dvalid & (~ivalid | (starve_cnt < CNT_W'(MAX_STARVE)));
        grant_c = arb_en & (d_win | ivalid);
        sel_c   = d_win ? SEL_D : SEL_I;
    end

    // Consecutive dbus grants while ibus waits; cleared by an ibus grant or an uncontended dbus grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (grant_c) begin
            if (sel_c == SEL_D && ivalid) begin
                if (starve_cnt != CNT_W'(MAX_STARVE)) begin
                    starve_cnt <= starve_cnt + CNT_W'(1);
                end
            end else begin
                starve_cnt <= '0;
            end
        end
    end
`endif

endmodule

// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter: serialises core ibus (fetch) and dbus (memory stage) requests onto one cbus.
// Ports: clk, reset_n (async active-low), bus (core_bus_arbiter_if.slave: ireq/dreq/cresp in,
//        iresp/dresp/creq out).
// The grant is locked for a whole transaction; creq is driven from a request captured at grant.
// iresp/dresp are combinational from cresp so that addr_ok/data_ok land in the last-beat cycle.
// Option CORE_BUS_ARB_RR_EN selects round-robin arbitration (see bus_arb_grant).
module core_bus_arbiter
    import core_bus_arbiter_pkg::*;
#(
    parameter int unsigned MAX_STARVE = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    core_bus_arbiter_if.slave   bus
);

    localparam logic [1:0] S_IDLE   = 2'(IDLE);
    localparam logic [1:0] S_BUSY_I = 2'(BUSY_I);
    localparam logic [1:0] S_BUSY_D = 2'(BUSY_D);

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       grant_c;
    arb_sel_t   sel_c;
    logic       done_c;
    cbus_req_t  creq_q;

    bus_arb_grant #(.MAX_STARVE(MAX_STARVE)) u_grant (
        .clk     (clk),
        .reset_n (reset_n),
        .arb_en  (state_q == S_IDLE),
        .ivalid  (bus.ireq.valid),
        .dvalid  (bus.dreq.valid),
        .grant_c (grant_c),
        .sel_c   (sel_c)
    );

    assign done_c = bus.cresp.ready & bus.cresp.last & (state_q != S_IDLE);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: leaving BUSY always passes through IDLE, so no same-cycle regrant.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (grant_c) begin
                    state_d = (sel_c == SEL_D) ? S_BUSY_D : S_BUSY_I;
                end
            end
            S_BUSY_I, S_BUSY_D: begin
                if (done_c) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request hold register: valid exactly while a transaction is outstanding.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            creq_q <= '0;
        end else if (grant_c) begin
            creq_q       <= (sel_c == SEL_D) ? dbus_to_cbus(bus.dreq) : ibus_to_cbus(bus.ireq);
            creq_q.valid <= 1'b1;
        end else if (done_c) begin
            creq_q.valid <= 1'b0;
        end
    end

    assign bus.creq = creq_q;

    // Response steering to the granted side only; fetch picks the 32-bit half by addr[2].
    always_comb begin
        bus.iresp = '0;
        bus.dresp = '0;
        if (done_c && state_q == S_BUSY_I) begin
            bus.iresp.addr_ok = 1'b1;
            bus.iresp.data_ok = 1'b1;
            bus.iresp.data    = creq_q.addr[2] ? bus.cresp.data[63:32] : bus.cresp.data[31:0];
        end
        if (done_c && state_q == S_BUSY_D) begin
            bus.dresp.addr_ok = 1'b1;
            bus.dresp.data_ok = 1'b1;
            bus.dresp.data    = bus.cresp.data;
        end
    end

endmodule
